// File: rtl/osc_sequencer.sv
// osc_sequencer: control block for the recursive sine oscillator.
// Captures a frequency configuration over a valid/ready handshake. It then
// issues a one-cycle Ready load pulse to the oscillator, followed by Enable
// step strobes every div+1 cycles. After every `reload` steps it re-seeds the
// oscillator with another load pulse.
// Ports:
//   Fg_CLK, RESETn          clock (rising edge), async active-low reset
//   cfg_valid / cfg_ready   config handshake
//   cfg_init1, cfg_init2    seed sin(B) and coefficient 2cos(w)
//   cfg_div                 Enable period minus 1
//   cfg_reload              Enable steps between re-seeds (0 = never)
//   stop                    abort to idle; outranks a simultaneous handshake
//   Ready, Enable           oscillator load / step strobes
//   init1, init2            held shadows driven to the oscillator
//   sample_valid            Enable delayed one cycle
//   busy                    sequencer is not idle
module osc_sequencer #(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned RLD_W = 16
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [31:0]       cfg_init1,
  input  logic [31:0]       cfg_init2,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [RLD_W-1:0]  cfg_reload,
  input  logic              stop,
  output logic              Ready,
  output logic              Enable,
  output logic [31:0]       init1,
  output logic [31:0]       init2,
  output logic              sample_valid,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q;
  logic [RLD_W-1:0]   reload_q;
  logic [DIV_W-1:0]   dcnt_q;
  logic [RLD_W-1:0]   scnt_q;
  logic [RLD_W-1:0]   scnt_inc;
  logic               handshake;

  // All strobes are decoded from registered state only.
  assign cfg_ready = ((state_q == S_IDLE) || (state_q == S_RUN)) && !stop;
  assign handshake = cfg_valid && cfg_ready;
  assign Ready     = (state_q == S_LOAD);
  assign Enable    = (state_q == S_RUN) && (dcnt_q == '0);
  assign busy      = (state_q != S_IDLE);
  assign scnt_inc  = scnt_q + RLD_W'(1);

  // Priority order: stop, then handshake, then the reseed decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (Enable && (reload_q != '0) && (scnt_inc == reload_q))
          state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
    if (handshake)
      state_d = S_LOAD;
    if (stop)
      state_d = S_IDLE;
  end

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= S_IDLE;
      init1        <= '0;
      init2        <= '0;
      div_q        <= '0;
      reload_q     <= '0;
      dcnt_q       <= '0;
      scnt_q       <= '0;
      sample_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_valid <= Enable;
      if (handshake) begin
        init1    <= cfg_init1;
        init2    <= cfg_init2;
        div_q    <= cfg_div;
        reload_q <= cfg_reload;
      end
      if (state_q == S_LOAD) begin
        dcnt_q <= '0;
        scnt_q <= '0;
      end else if (state_q == S_RUN) begin
        dcnt_q <= (dcnt_q == div_q) ? '0 : dcnt_q + DIV_W'(1);
        if (Enable)
          scnt_q <= scnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_osc_sequencer.sv
module tb_osc_sequencer;

  logic        Fg_CLK;
  logic        RESETn;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_init1;
  logic [31:0] cfg_init2;
  logic [15:0] cfg_div;
  logic [15:0] cfg_reload;
  logic        stop;
  logic        Ready;
  logic        Enable;
  logic [31:0] init1;
  logic [31:0] init2;
  logic        sample_valid;
  logic        busy;

  int unsigned passed = 0;
  int unsigned total  = 0;

  osc_sequencer #(.DIV_W(16), .RLD_W(16)) dut (
    .Fg_CLK       (Fg_CLK),
    .RESETn       (RESETn),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_init1    (cfg_init1),
    .cfg_init2    (cfg_init2),
    .cfg_div      (cfg_div),
    .cfg_reload   (cfg_reload),
    .stop         (stop),
    .Ready        (Ready),
    .Enable       (Enable),
    .init1        (init1),
    .init2        (init2),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  initial Fg_CLK = 1'b0;
  always #5 Fg_CLK = ~Fg_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Fg_CLK);
    #1;
  endtask

  task automatic offer(input logic [31:0] i1, input logic [31:0] i2,
                       input logic [15:0] d, input logic [15:0] r);
    cfg_valid  = 1'b1;
    cfg_init1  = i1;
    cfg_init2  = i2;
    cfg_div    = d;
    cfg_reload = r;
  endtask

  logic [9:0] en_pat;
  logic [9:0] sv_pat;
  logic [9:0] rdy_pat;

  initial begin
    RESETn     = 1'b0;
    cfg_valid  = 1'b0;
    cfg_init1  = '0;
    cfg_init2  = '0;
    cfg_div    = '0;
    cfg_reload = '0;
    stop       = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_ready",     {31'd0, Ready},        32'd0);
    chk("rst_enable",    {31'd0, Enable},       32'd0);
    chk("rst_sv",        {31'd0, sample_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},         32'd0);
    chk("rst_cfg_ready", {31'd0, cfg_ready},    32'd1);
    chk("rst_init1",     init1,                 32'd0);
    chk("rst_init2",     init2,                 32'd0);
    RESETn = 1'b1;
    tick();

    // div=3, reload=0: Ready in k+1, Enable at k+2, k+6, k+10
    offer(32'h1000_0000, 32'h3B20_D79E, 16'd3, 16'd0);
    #1;
    chk("t1_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    tick();
    cfg_valid = 1'b0;
    chk("t1_load_ready",  {31'd0, Ready},  32'd1);
    chk("t1_load_enable", {31'd0, Enable}, 32'd0);
    chk("t1_load_busy",   {31'd0, busy},   32'd1);
    chk("t1_init1",       init1,           32'h1000_0000);
    chk("t1_init2",       init2,           32'h3B20_D79E);
    // cycles k+2 .. k+11
    en_pat = 10'b1000100010;
    sv_pat = 10'b0100010001;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t1_en_%0d", i),  {31'd0, Enable},       {31'd0, en_pat[9-i]});
      chk($sformatf("t1_sv_%0d", i),  {31'd0, sample_valid}, {31'd0, sv_pat[9-i]});
      chk($sformatf("t1_rdy_%0d", i), {31'd0, Ready},        32'd0);
    end

    // New handshake in RUN at k+11 (dcnt=1): LOAD, then div count restarts
    offer(32'h1000_0000, 32'h2000_0000, 16'd3, 16'd0);
    tick();
    cfg_valid = 1'b0;
    chk("t3_load_ready",  {31'd0, Ready},  32'd1);
    chk("t3_load_enable", {31'd0, Enable}, 32'd0);
    chk("t3_init2",       init2,           32'h2000_0000);
    en_pat = 10'b1000100000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t3_en_%0d", i),  {31'd0, Enable}, {31'd0, en_pat[9-i]});
      chk($sformatf("t3_rdy_%0d", i), {31'd0, Ready},  32'd0);
    end

    // stop together with cfg_valid in RUN (this cycle has Enable=1)
    stop = 1'b1;
    offer(32'hDEAD_BEEF, 32'h0BAD_F00D, 16'd7, 16'd9);
    #1;
    chk("t4_cfg_ready_stop", {31'd0, cfg_ready}, 32'd0);
    tick();
    chk("t4_busy",   {31'd0, busy},         32'd0);
    chk("t4_enable", {31'd0, Enable},       32'd0);
    chk("t4_ready",  {31'd0, Ready},        32'd0);
    chk("t4_sv",     {31'd0, sample_valid}, 32'd1);
    chk("t4_init1",  init1,                 32'h1000_0000);
    chk("t4_init2",  init2,                 32'h2000_0000);
    stop = 1'b0;
    offer(32'h1234_5678, 32'h2000_0000, 16'd0, 16'd4);
    #1;
    chk("t4_cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
    tick();
    cfg_valid = 1'b0;
    chk("t4_restart_ready", {31'd0, Ready}, 32'd1);
    chk("t4_restart_init1", init1,          32'h1234_5678);

    // div=0, reload=4: Enable 1111 0 1111 0, Ready in each gap
    en_pat  = 10'b1111011110;
    rdy_pat = 10'b0000100001;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t2_en_%0d", i),  {31'd0, Enable}, {31'd0, en_pat[9-i]});
      chk($sformatf("t2_rdy_%0d", i), {31'd0, Ready},  {31'd0, rdy_pat[9-i]});
    end
    tick();
    chk("t2_en_after_reseed", {31'd0, Enable}, 32'd1);

    // Asynchronous reset mid-RUN
    #2;
    RESETn = 1'b0;
    #1;
    chk("t5_enable",    {31'd0, Enable},       32'd0);
    chk("t5_ready",     {31'd0, Ready},        32'd0);
    chk("t5_sv",        {31'd0, sample_valid}, 32'd0);
    chk("t5_busy",      {31'd0, busy},         32'd0);
    chk("t5_cfg_ready", {31'd0, cfg_ready},    32'd1);
    chk("t5_init1",     init1,                 32'd0);
    chk("t5_init2",     init2,                 32'd0);
    #1;
    RESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5_idle_en_%0d", i), {31'd0, Enable}, 32'd0);
      chk($sformatf("t5_idle_busy_%0d", i), {31'd0, busy}, 32'd0);
    end

    // reload=2, div=1; new handshake on the 2nd Enable wins over the reseed
    offer(32'hAAAA_0001, 32'h3000_0000, 16'd1, 16'd2);
    tick();
    cfg_valid = 1'b0;
    chk("t6_c0_ready", {31'd0, Ready}, 32'd1);
    tick();
    chk("t6_c1_en", {31'd0, Enable}, 32'd1);
    tick();
    chk("t6_c2_en", {31'd0, Enable}, 32'd0);
    tick();
    chk("t6_c3_en", {31'd0, Enable}, 32'd1);
    offer(32'hBBBB_0002, 32'h3100_0000, 16'd1, 16'd2);
    tick();
    cfg_valid = 1'b0;
    chk("t6_c4_ready",  {31'd0, Ready},  32'd1);
    chk("t6_c4_enable", {31'd0, Enable}, 32'd0);
    chk("t6_c4_init1",  init1,           32'hBBBB_0002);
    chk("t6_c4_init2",  init2,           32'h3100_0000);
    tick();
    chk("t6_c5_ready", {31'd0, Ready},  32'd0);
    chk("t6_c5_en",    {31'd0, Enable}, 32'd1);
    tick();
    chk("t6_c6_en", {31'd0, Enable}, 32'd0);
    tick();
    chk("t6_c7_en", {31'd0, Enable}, 32'd1);
    tick();
    chk("t6_c8_ready", {31'd0, Ready}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
